or_event_collector: RTL and testbench
=====================================

// Module: or_event_collector
// PURPOSE
//  Upstream feeder for the OR-gate stage. Detects rising edges on N event lines and
//  holds each in a sticky pending bit. Drives a masked OR-reduced irq into the
//  downstream OR logic. Pending bits are cleared through a 4-phase req/ack handshake.
//  Also keeps a saturating count of all detected events.
// PARAMETERS
//  N      4  number of event input lines (1..16)
//  CNT_W  8  width of event counter evt_cnt
// PORTS
//  clk       in   1      single clock, all state on rising edge
//  rst       in   1      asynchronous reset, active-high
//  evt_in    in   N      event lines, synchronous to clk
//  mask      in   N      1 = bit may drive irq (does not gate pending capture)
//  clr_req   in   1      clear request, level, 4-phase handshake
//  clr_mask  in   N      pending bits to clear, sampled when request accepted
//  clr_ack   out  1      clear acknowledge
//  pending   out  N      sticky pending flags (registered)
//  irq       out  1      |(pending & mask), combinational from registers
//  evt_cnt   out  CNT_W  saturating count of detected rising edges
//  overflow  out  1      sticky, set when an increment is lost to saturation
// BEHAVIOUR
//  Reset (async, rst=1):
//   - pending=0, evt_cnt=0, overflow=0, clr_ack=0, FSM=IDLE.
//   - Edge register evt_q is set to all ones, so a line already high at reset release is not an event.
//  Edge detect:
//   - rise = evt_in & ~evt_q; evt_q <= evt_in every cycle.
//   - Pending bit sets on the edge after rise is seen; irq follows in the same cycle (latency 1).
//  Counter:
//   - evt_cnt += popcount(rise) each cycle, saturating at 2^CNT_W-1.
//   - If the sum would exceed max, evt_cnt = max and overflow <= 1.
//   - overflow is cleared only by reset.
//  Clear FSM, states IDLE / CLEAR / ACK:
//   - IDLE: clr_req=1 -> latch clr_mask into cm_q, go to CLEAR.
//   - CLEAR (one cycle): pending <= (pending & ~cm_q) | rise. Go to ACK.
//   - ACK: clr_ack=1. Stay while clr_req=1; go to IDLE when clr_req=0 (clr_ack low in IDLE).
//   - clr_ack is a registered Moore output: high exactly while in ACK.
//   - A clr_req held high across ACK->IDLE is not re-accepted until it has been seen low.
//  Simultaneous events:
//   - A rise on a bit being cleared in the CLEAR cycle wins: the bit stays 1 and is counted.
//   - Rises in IDLE or ACK always set pending.
//   - clr_mask=0 completes the handshake with no effect.
//  mask changes affect irq combinationally. A masked pending bit stays set and is still visible on pending.
//  rst mid-handshake: FSM returns to IDLE, clr_ack drops at once, all state cleared as at reset.
// TESTING
//  1 Reset release with evt_in=4'b0010 held -> pending=0, evt_cnt=0; then evt_in[1] 0->1 -> pending=4'b0010, evt_cnt=1, irq=1 (mask=4'hF).
//  2 Rise on bits 0 and 3 in one cycle, mask=4'b0001 -> pending=4'b1001, evt_cnt+=2, irq=1; mask=4'b0100 -> irq=0.
//  3 clr_req=1, clr_mask=4'b1001 -> clr_ack high 2 cycles later, pending=0. Hold req 5 cycles -> ack held 5 cycles. Drop req -> ack low next cycle.
//  4 Rise on bit 0 in the CLEAR cycle with clr_mask=4'b0001 -> pending[0]=1 after ack, evt_cnt incremented.
//  5 CNT_W=2, 5 single rises -> evt_cnt=3, overflow=1 after the 4th rise; stays 1 until rst.
//  6 Assert rst while clr_ack=1 -> clr_ack, pending, evt_cnt, overflow all 0 asynchronously; FSM in IDLE.

Source files
------------

// File: rtl/or_event_collector.sv
// Rising-edge event collector: sticky pending flags, masked OR irq, saturating event
// counter, and a 4-phase req/ack handshake for clearing pending bits.
module or_event_collector #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     evt_in,
    input  logic [N-1:0]     mask,
    input  logic             clr_req,
    input  logic [N-1:0]     clr_mask,
    output logic             clr_ack,
    output logic [N-1:0]     pending,
    output logic             irq,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             overflow
);

    // state | meaning
    // IDLE  | waiting for clr_req, clr_ack low
    // CLEAR | one cycle, applies cm_q to pending (same-cycle rises win)
    // ACK   | clr_ack high until clr_req is seen low
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam int SW = CNT_W + 5;
    localparam logic [SW-1:0] CNT_MAX = {{5{1'b0}}, {CNT_W{1'b1}}};

    state_t          state;
    logic [N-1:0]    evt_q;
    logic [N-1:0]    cm_q;
    logic [N-1:0]    rise;
    logic [4:0]      rise_cnt;
    logic [SW-1:0]   sum;

    assign rise = evt_in & ~evt_q;
    assign irq  = |(pending & mask);

    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < N; i++) begin
            rise_cnt = rise_cnt + 5'(rise[i]);
        end
    end

    assign sum = SW'(evt_cnt) + SW'(rise_cnt);

    // evt_q resets to ones so lines already high at reset release are not events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_q    <= '1;
            evt_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            evt_q <= evt_in;
            if (sum > CNT_MAX) begin
                evt_cnt  <= '1;
                overflow <= 1'b1;
            end else begin
                evt_cnt <= sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cm_q    <= '0;
            clr_ack <= 1'b0;
            pending <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pending <= pending | rise;
                    if (clr_req) begin
                        cm_q  <= clr_mask;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    pending <= (pending & ~cm_q) | rise;
                    state   <= ACK;
                    clr_ack <= 1'b1;
                end
                ACK: begin
                    pending <= pending | rise;
                    if (!clr_req) begin
                        state   <= IDLE;
                        clr_ack <= 1'b0;
                    end
                end
                default: begin
                    pending <= pending | rise;
                    state   <= IDLE;
                    clr_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_or_event_collector.sv
// Directed testbench for or_event_collector: default instance plus a CNT_W=2
// instance for saturation.
module tb_or_event_collector;

    logic       clk;
    logic       rst;
    logic [3:0] evt_in;
    logic [3:0] mask;
    logic       clr_req;
    logic [3:0] clr_mask;
    logic       clr_ack;
    logic [3:0] pending;
    logic       irq;
    logic [7:0] evt_cnt;
    logic       overflow;

    logic [3:0] s_evt_in;
    logic [3:0] s_mask;
    logic       s_clr_req;
    logic [3:0] s_clr_mask;
    logic       s_clr_ack;
    logic [3:0] s_pending;
    logic       s_irq;
    logic [1:0] s_evt_cnt;
    logic       s_overflow;

    int vectors;
    int miscompares;

    or_event_collector #(.N(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .evt_in(evt_in), .mask(mask),
        .clr_req(clr_req), .clr_mask(clr_mask), .clr_ack(clr_ack),
        .pending(pending), .irq(irq), .evt_cnt(evt_cnt), .overflow(overflow)
    );

    or_event_collector #(.N(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .evt_in(s_evt_in), .mask(s_mask),
        .clr_req(s_clr_req), .clr_mask(s_clr_mask), .clr_ack(s_clr_ack),
        .pending(s_pending), .irq(s_irq), .evt_cnt(s_evt_cnt), .overflow(s_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (pending !== 4'b0000 || evt_cnt !== 8'd0 || clr_ack !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: pending=%b cnt=%0d ack=%b ovf=%b, expected 0000/0/0/0",
                     pending, evt_cnt, clr_ack, overflow);
        end
        step();
        rst = 1'b0;
        step();
        vectors++;
        if (pending !== 4'b0000 || evt_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_release_high_line: pending=%b cnt=%0d, expected 0000/0", pending, evt_cnt);
        end
        evt_in = 4'b0000;
        step();
        evt_in = 4'b0010;
        step();
        vectors++;
        if (pending !== 4'b0010 || evt_cnt !== 8'd1 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL first_rise: pending=%b cnt=%0d irq=%b, expected 0010/1/1", pending, evt_cnt, irq);
        end
    endtask

    task automatic test_multi_rise();
        evt_in = 4'b1011;
        mask   = 4'b0001;
        step();
        vectors++;
        if (pending !== 4'b1011 || evt_cnt !== 8'd3 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL multi_rise: pending=%b cnt=%0d irq=%b, expected 1011/3/1", pending, evt_cnt, irq);
        end
        mask = 4'b0100;
        #1;
        vectors++;
        if (irq !== 1'b0 || pending !== 4'b1011) begin
            miscompares++;
            $display("FAIL mask_off: irq=%b pending=%b, expected 0/1011", irq, pending);
        end
        mask = 4'b0010;
        #1;
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_on: irq=%b, expected 1", irq);
        end
    endtask

    task automatic test_clear();
        clr_mask = 4'b1001;
        clr_req  = 1'b1;
        step();
        vectors++;
        if (clr_ack !== 1'b0 || pending !== 4'b1011) begin
            miscompares++;
            $display("FAIL clear_cycle1: ack=%b pending=%b, expected 0/1011", clr_ack, pending);
        end
        clr_mask = 4'b0000;
        step();
        vectors++;
        if (clr_ack !== 1'b1 || pending !== 4'b0010) begin
            miscompares++;
            $display("FAIL clear_ack: ack=%b pending=%b, expected 1/0010", clr_ack, pending);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (clr_ack !== 1'b1) begin
                miscompares++;
                $display("FAIL ack_hold[%0d]: ack=%b, expected 1", i, clr_ack);
            end
        end
        clr_req = 1'b0;
        step();
        vectors++;
        if (clr_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_drop: ack=%b, expected 0", clr_ack);
        end
        step();
        vectors++;
        if (clr_ack !== 1'b0 || pending !== 4'b0010) begin
            miscompares++;
            $display("FAIL idle_quiet: ack=%b pending=%b, expected 0/0010", clr_ack, pending);
        end
    endtask

    task automatic test_clear_race();
        evt_in = 4'b0000;
        step();
        clr_mask = 4'b0001;
        clr_req  = 1'b1;
        step();
        evt_in = 4'b0001;
        step();
        vectors++;
        if (pending !== 4'b0011 || evt_cnt !== 8'd4 || clr_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_race: pending=%b cnt=%0d ack=%b, expected 0011/4/1", pending, evt_cnt, clr_ack);
        end
        clr_req = 1'b0;
        step();
        clr_mask = 4'b0000;
        clr_req  = 1'b1;
        step();
        step();
        vectors++;
        if (pending !== 4'b0011 || clr_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_zero_mask: pending=%b ack=%b, expected 0011/1", pending, clr_ack);
        end
        clr_req = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 5; k++) begin
            s_evt_in = 4'b0001;
            step();
            vectors++;
            if (s_evt_cnt !== ((k > 3) ? 2'd3 : 2'(k)) || s_overflow !== (k >= 4)) begin
                miscompares++;
                $display("FAIL sat_rise[%0d]: cnt=%0d ovf=%b, expected %0d/%b",
                         k, s_evt_cnt, s_overflow, (k > 3) ? 3 : k, (k >= 4));
            end
            s_evt_in = 4'b0000;
            step();
        end
        step();
        vectors++;
        if (s_overflow !== 1'b1 || s_evt_cnt !== 2'd3) begin
            miscompares++;
            $display("FAIL sat_sticky: cnt=%0d ovf=%b, expected 3/1", s_evt_cnt, s_overflow);
        end
    endtask

    task automatic test_reset_mid();
        clr_mask = 4'b0011;
        clr_req  = 1'b1;
        step();
        step();
        vectors++;
        if (clr_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_rst_ack: ack=%b, expected 1", clr_ack);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (clr_ack !== 1'b0 || pending !== 4'b0000 || evt_cnt !== 8'd0 ||
            s_overflow !== 1'b0 || s_evt_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL async_rst: ack=%b pending=%b cnt=%0d s_ovf=%b s_cnt=%0d, expected 0/0000/0/0/0",
                     clr_ack, pending, evt_cnt, s_overflow, s_evt_cnt);
        end
        clr_req = 1'b0;
        step();
        rst = 1'b0;
        step();
        vectors++;
        if (clr_ack !== 1'b0 || pending !== 4'b0000 || evt_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL post_rst: ack=%b pending=%b cnt=%0d, expected 0/0000/0", clr_ack, pending, evt_cnt);
        end
        clr_req = 1'b1;
        step();
        step();
        vectors++;
        if (clr_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL post_rst_handshake: ack=%b, expected 1", clr_ack);
        end
        clr_req = 1'b0;
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst        = 1'b1;
        evt_in     = 4'b0010;
        mask       = 4'hF;
        clr_req    = 1'b0;
        clr_mask   = 4'b0000;
        s_evt_in   = 4'b0000;
        s_mask     = 4'hF;
        s_clr_req  = 1'b0;
        s_clr_mask = 4'b0000;

        test_reset();
        test_multi_rise();
        test_clear();
        test_clear_race();
        test_saturation();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
